// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its bench.
//   ADDR_W_DEF     : default instruction-memory word-address width
//   BYTES_PER_WORD : bytes assembled into one 32-bit instruction word
//   BCNT_W         : width of the byte-within-word counter
//   ld_state_t     : loader FSM state encoding
package im_loader_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/im_loader_if.sv
// Loader control, byte-stream and instruction-memory signals.
//   master : the side that issues start/word_count and sources the byte stream
//   slave  : the loader itself (drives byte_ready, memory write port, cpu_rst, done)
interface im_loader_if #(
  parameter int ADDR_W = im_loader_pkg::ADDR_W_DEF
);

  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_din;
  logic              cpu_rst;
  logic              done;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_din, cpu_rst, done
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_din, cpu_rst, done
  );

endinterface

// File: rtl/im_loader_byte_packer.sv
// Assembles a big-endian 32-bit word from a byte stream.
//   clk, rst   : clock, async active-high reset
//   clear      : restart at byte 0 of a word (new load)
//   accept     : byte_in is taken this cycle
//   byte_in    : incoming byte
//   word_out   : assembled word; first accepted byte ends up in [31:24]
//   word_done  : this accept completes the word (4th byte)
module im_loader_byte_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_done
);

  logic [BCNT_W-1:0] cnt_q;

  // Left shift puts the earliest byte in the MSBs once four bytes are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out <= '0;
      cnt_q    <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (accept) begin
      word_out <= {word_out[23:0], byte_in};
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign word_done = accept && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_loader.sv
// Loads a program into instruction memory from a byte stream while holding
// the processor core in reset, then releases it.
//   clk, rst : clock, async active-high reset
//   bus      : start/word_count request, byte stream (valid/ready/data),
//              memory write port (im_we/im_addr/im_din), cpu_rst and done
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start, core held in reset
// ST_RECV  | byte_ready high, collecting the 4 bytes of the current word
// ST_WRITE | one-cycle im_we pulse for the assembled word
// ST_DONE  | load complete, core released; start begins a new load
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  im_loader_if.slave   bus
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              ready_q;
  logic              done_q;
  logic              cpu_rst_q;

  logic              accept;
  logic              start_ok;
  logic              word_done;
  logic              last_word;
  logic [ADDR_W:0]   count_in;
  logic [31:0]       packed_word;

  assign accept   = bus.byte_valid && ready_q;
  assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign count_in = (bus.word_count > MAX_WORDS) ? MAX_WORDS : bus.word_count;
  // Compare against count-1 rather than incrementing first, so a full
  // 2^ADDR_W load finishes at the top address without the counter wrapping.
  assign last_word = ({1'b0, addr_q} == (count_q - 1'b1));

  im_loader_byte_packer u_byte_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .accept    (accept),
    .byte_in   (bus.byte_data),
    .word_out  (packed_word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            count_q <= count_in;
            addr_q  <= '0;
            if (count_in == '0) begin
              state_q   <= ST_DONE;
              ready_q   <= 1'b0;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q   <= ST_RECV;
              ready_q   <= 1'b1;
              done_q    <= 1'b0;
              cpu_rst_q <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (word_done) begin
            state_q <= ST_WRITE;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (last_word) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b0;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= ST_RECV;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b0;
          done_q    <= 1'b0;
          cpu_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.im_we      = we_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_din     = packed_word;
  assign bus.done       = done_q;
  assign bus.cpu_rst    = cpu_rst_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: reset values, zero-length load, continuous
// and throttled streams, ignored/restarting start, full-size clamp, and
// reset in the middle of a load.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int ADDR_W = ADDR_W_DEF;
  localparam int LIMIT  = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0]        byte_src [0:4095];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      wr_addr_q.push_back(bus.im_addr);
      wr_data_q.push_back(bus.im_din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then stream nbytes from byte_src. cycles counts edges after
  // the start edge. post_start = {cpu_rst, done, byte_ready} right after start.
  task automatic run_load(input logic [ADDR_W:0] wc, input int nbytes,
                          input bit toggle, input int start_mid, input bit abort,
                          output int cycles, output bit early_wr,
                          output logic [2:0] post_start);
    int  idx;
    bit  acc;
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.start      = 1'b1;
    bus.word_count = wc;
    tick();
    bus.start  = 1'b0;
    post_start = {bus.cpu_rst, bus.done, bus.byte_ready};
    idx      = 0;
    cycles   = 0;
    early_wr = 1'b0;
    while (cycles < LIMIT) begin
      bus.byte_valid = (idx < nbytes) && (!toggle || (cycles % 2 == 1));
      bus.byte_data  = (idx < nbytes) ? byte_src[idx] : 8'h00;
      bus.start      = (cycles == start_mid);
      bus.word_count = (cycles == start_mid) ? '0 : wc;
      acc = bus.byte_valid && bus.byte_ready;
      tick();
      cycles++;
      bus.start = 1'b0;
      if (acc) idx++;
      if (wr_data_q.size() > idx / 4) early_wr = 1'b1;
      if (bus.done === 1'b1 || (abort && idx == nbytes)) break;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vec_cnt++; if (bus.byte_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_byte_ready got %b want 0", bus.byte_ready); end
    vec_cnt++; if (bus.im_we !== 1'b0) begin err_cnt++; $display("FAIL reset_im_we got %b want 0", bus.im_we); end
    vec_cnt++; if (bus.im_addr !== '0) begin err_cnt++; $display("FAIL reset_im_addr got %h want 0", bus.im_addr); end
    vec_cnt++; if (bus.im_din !== 32'h0) begin err_cnt++; $display("FAIL reset_im_din got %h want 0", bus.im_din); end
    vec_cnt++; if (bus.done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", bus.done); end
    vec_cnt++; if (bus.cpu_rst !== 1'b1) begin err_cnt++; $display("FAIL reset_cpu_rst got %b want 1", bus.cpu_rst); end
    rst = 1'b0;
    tick();
    vec_cnt++; if (bus.cpu_rst !== 1'b1 || bus.done !== 1'b0) begin err_cnt++; $display("FAIL idle_outputs got cpu_rst=%b done=%b want 1/0", bus.cpu_rst, bus.done); end
  endtask

  task automatic test_zero_count();
    int cyc; bit early; logic [2:0] ps;
    run_load('0, 0, 1'b0, -1, 1'b0, cyc, early, ps);
    vec_cnt++; if (ps !== 3'b010) begin err_cnt++; $display("FAIL zero_post_start {cpu_rst,done,ready} got %b want 010", ps); end
    repeat (4) tick();
    vec_cnt++; if (wr_data_q.size() != 0) begin err_cnt++; $display("FAIL zero_no_write got %0d writes want 0", wr_data_q.size()); end
  endtask

  task automatic test_two_words();
    int cyc; bit early; logic [2:0] ps;
    byte_src[0] = 8'h20; byte_src[1] = 8'h08; byte_src[2] = 8'h00; byte_src[3] = 8'h05;
    byte_src[4] = 8'hAC; byte_src[5] = 8'h08; byte_src[6] = 8'h00; byte_src[7] = 8'h00;
    run_load(11'd2, 8, 1'b0, -1, 1'b0, cyc, early, ps);
    vec_cnt++; if (ps !== 3'b101) begin err_cnt++; $display("FAIL two_restart_from_done got %b want 101", ps); end
    vec_cnt++; if (wr_data_q.size() != 2) begin err_cnt++; $display("FAIL two_write_count got %0d want 2", wr_data_q.size()); end
    else begin
      vec_cnt++; if (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h20080005) begin err_cnt++; $display("FAIL two_word0 got %h@%0d want 20080005@0", wr_data_q[0], wr_addr_q[0]); end
      vec_cnt++; if (wr_addr_q[1] !== 10'd1 || wr_data_q[1] !== 32'hAC080000) begin err_cnt++; $display("FAIL two_word1 got %h@%0d want ac080000@1", wr_data_q[1], wr_addr_q[1]); end
    end
    // start on edge 0, done visible after edge 10 (the 11th cycle)
    vec_cnt++; if (cyc != 10 || bus.done !== 1'b1 || bus.cpu_rst !== 1'b0) begin err_cnt++; $display("FAIL two_done_latency got %0d cycles done=%b cpu_rst=%b want 10/1/0", cyc, bus.done, bus.cpu_rst); end
  endtask

  task automatic test_toggle_valid();
    int cyc; bit early; logic [2:0] ps;
    byte_src[0] = 8'h12; byte_src[1] = 8'h34; byte_src[2] = 8'h56; byte_src[3] = 8'h78;
    run_load(11'd1, 4, 1'b1, -1, 1'b0, cyc, early, ps);
    vec_cnt++; if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'h12345678 || wr_addr_q[0] !== 10'd0) begin err_cnt++; $display("FAIL toggle_write got n=%0d first=%h want 1 x 12345678@0", wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0); end
    vec_cnt++; if (early !== 1'b0) begin err_cnt++; $display("FAIL toggle_early_write got %b want 0", early); end
    vec_cnt++; if (bus.done !== 1'b1) begin err_cnt++; $display("FAIL toggle_done got %b want 1", bus.done); end
  endtask

  task automatic test_start_ignored();
    int cyc; bit early; logic [2:0] ps;
    byte_src[0] = 8'h01; byte_src[1] = 8'h02; byte_src[2] = 8'h03; byte_src[3] = 8'h04;
    byte_src[4] = 8'h05; byte_src[5] = 8'h06; byte_src[6] = 8'h07; byte_src[7] = 8'h08;
    // start with word_count=0 during RECV
    run_load(11'd2, 8, 1'b0, 2, 1'b0, cyc, early, ps);
    vec_cnt++; if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h01020304 || wr_data_q[1] !== 32'h05060708) begin err_cnt++; $display("FAIL recv_start_ignored got n=%0d want 2 words 01020304,05060708", wr_data_q.size()); end
    vec_cnt++; if (cyc != 10) begin err_cnt++; $display("FAIL recv_start_latency got %0d want 10", cyc); end
    // start with word_count=0 during WRITE (cycle 4 drives the edge sampled in WRITE)
    run_load(11'd2, 8, 1'b0, 4, 1'b0, cyc, early, ps);
    vec_cnt++; if (wr_data_q.size() != 2 || cyc != 10) begin err_cnt++; $display("FAIL write_start_ignored got n=%0d cyc=%0d want 2/10", wr_data_q.size(), cyc); end
  endtask

  task automatic test_restart();
    int cyc; bit early; logic [2:0] ps;
    byte_src[0] = 8'hCA; byte_src[1] = 8'hFE; byte_src[2] = 8'hF0; byte_src[3] = 8'h0D;
    vec_cnt++; if (bus.done !== 1'b1) begin err_cnt++; $display("FAIL restart_pre_done got %b want 1", bus.done); end
    run_load(11'd1, 4, 1'b0, -1, 1'b0, cyc, early, ps);
    vec_cnt++; if (ps !== 3'b101) begin err_cnt++; $display("FAIL restart_post_start got %b want 101", ps); end
    vec_cnt++; if (wr_data_q.size() != 1 || wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL restart_write got n=%0d want cafef00d@0", wr_data_q.size()); end
  endtask

  task automatic test_clamp_full();
    int cyc; bit early; logic [2:0] ps; int bad;
    logic [31:0] exp;
    for (int i = 0; i < 4096; i++) byte_src[i] = 8'(i * 7 + (i >> 8));
    run_load(11'd2000, 4096, 1'b0, -1, 1'b0, cyc, early, ps);
    vec_cnt++; if (wr_data_q.size() != 1024) begin err_cnt++; $display("FAIL clamp_write_count got %0d want 1024", wr_data_q.size()); end
    else begin
      vec_cnt++; if (wr_addr_q[1023] !== 10'd1023) begin err_cnt++; $display("FAIL clamp_last_addr got %0d want 1023", wr_addr_q[1023]); end
      bad = 0;
      for (int k = 0; k < 1024; k++) begin
        exp = {byte_src[4*k], byte_src[4*k+1], byte_src[4*k+2], byte_src[4*k+3]};
        if (wr_addr_q[k] !== 10'(k) || wr_data_q[k] !== exp) bad++;
      end
      vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL clamp_contents got %0d bad words want 0", bad); end
    end
    vec_cnt++; if (cyc != 5120 || bus.done !== 1'b1) begin err_cnt++; $display("FAIL clamp_latency got %0d done=%b want 5120/1", cyc, bus.done); end
  endtask

  task automatic test_reset_mid_load();
    int cyc; bit early; logic [2:0] ps;
    for (int i = 0; i < 10; i++) byte_src[i] = 8'(8'h40 + i);
    run_load(11'd4, 10, 1'b0, -1, 1'b1, cyc, early, ps);
    vec_cnt++; if (wr_data_q.size() != 2) begin err_cnt++; $display("FAIL midrst_pre_writes got %0d want 2", wr_data_q.size()); end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++; if ({bus.byte_ready, bus.im_we, bus.done, bus.cpu_rst} !== 4'b0001 || bus.im_addr !== '0 || bus.im_din !== 32'h0)
      begin err_cnt++; $display("FAIL midrst_outputs got ready=%b we=%b done=%b cpu_rst=%b addr=%0d din=%h want 0/0/0/1/0/0",
                                bus.byte_ready, bus.im_we, bus.done, bus.cpu_rst, bus.im_addr, bus.im_din); end
    repeat (3) tick();
    vec_cnt++; if (wr_data_q.size() != 2) begin err_cnt++; $display("FAIL midrst_no_write got %0d want 2", wr_data_q.size()); end
    rst = 1'b0;
    tick();
    byte_src[0] = 8'hDE; byte_src[1] = 8'hAD; byte_src[2] = 8'hBE; byte_src[3] = 8'hEF;
    run_load(11'd1, 4, 1'b0, -1, 1'b0, cyc, early, ps);
    vec_cnt++; if (wr_data_q.size() != 1 || wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL midrst_reload got n=%0d want deadbeef@0", wr_data_q.size()); end
    vec_cnt++; if (bus.done !== 1'b1) begin err_cnt++; $display("FAIL midrst_reload_done got %b want 1", bus.done); end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_zero_count();
    test_two_words();
    test_toggle_valid();
    test_start_ignored();
    test_restart();
    test_clamp_full();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
